mux_tree_pipe: RTL
==================

# mux_tree_pipe

Parametrised, pipelined N-to-1 word multiplexer for the DLX datapath. It generalises the gate-level 2/4/8/32-to-1 bit muxes to WIDTH-bit words, any power-of-two input count, and configurable pipeline register insertion. It carries a valid tag per stage, with stall and flush controls. It serves wide operand, forwarding and register-read selection paths where a single-cycle 32-way word mux misses timing.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- NUM_IN, 32, number of inputs; power of two, ≥2
- REG_EVERY, 2, number of 2:1 tree levels per pipeline stage (≥1)
- Derived: SELW = log2(NUM_IN); L = SELW levels; S = ceil(L/REG_EVERY) stages
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  the current d/sel is a request
- sel  input  SELW  index of the selected input
- d  input  NUM_IN*WIDTH  packed inputs; input k = d[k*WIDTH +: WIDTH]
- stall  input  1  freeze all pipeline state
- flush  input  1  invalidate all in-flight requests
- out  output  WIDTH  selected word (final stage register)
- out_valid  output  1  out holds a result issued this cycle
- busy  output  1  OR of all stage valid bits, including the final stage

## Operation
- Tree: level j (j = 0..L-1) pairs entries 2i and 2i+1 of the previous level and selects with sel[j]. sel[j]=0 passes the even entry and sel[j]=1 the odd. Level 0 uses sel[0] (LSB first), matching the existing bit-mux trees.
- Stage s (s = 0..S-1) contains levels s*REG_EVERY .. min((s+1)*REG_EVERY, L)-1, then a register.
- Each stage register holds:
  - the partial results, NUM_IN>>(levels done) words;
  - the unconsumed sel bits;
  - a valid bit.
- The final stage register holds the single word, which drives out.
- Valid bits advance every non-stalled cycle. in_valid=0 inserts a bubble.
- Data and sel registers in a stage load only when the incoming valid is 1. Otherwise they hold. out therefore keeps the last valid result while out_valid=0.
- stall=1: no register changes, and in_valid/d/sel are not captured. Upstream must hold the request.
- flush=1: all valid bits clear at the next edge, and the data registers keep their values. A request presented with flush is discarded. flush has priority over stall.
- reset has priority over flush and stall. All valid bits clear, all data and sel registers clear, out=0.

## Timing
- Reset values: out=0, out_valid=0, busy=0.
- Latency: S cycles, no stall. A request captured at edge t appears on out with out_valid=1 after edge t+S-1. With S=1 it is registered on the same edge.
- Throughput: one request per cycle. There is no backpressure output; stall is the only throttle.
- NUM_IN=32, REG_EVERY=2 gives L=5, S=3: stages cover levels {0,1}, {2,3}, {4}.
- REG_EVERY ≥ L gives S=1: a purely registered single stage.
- Stall mid-flight: the pipeline position is preserved. Latency extends by exactly the number of stalled cycles.
- Reset mid-operation: all in-flight requests are lost, and out_valid stays 0 until a new request drains through.
- flush and in_valid in the same cycle: the request is dropped, and out_valid=0 for the next S cycles unless new requests are issued.

## Test plan
- Reset then idle (NUM_IN=32, WIDTH=32, REG_EVERY=2): d[k]=0x1000_0000+k, in_valid=0 -> out=0, out_valid=0, busy=0 for 10 cycles.
- Sweep: issue sel=0..31 back-to-back with d[k]=0x1000_0000+k -> from the 3rd cycle on, out=0x1000_0000+sel issued 3 cycles earlier, out_valid=1 every cycle for 32 cycles.
- Bubble hold: sel=5 valid, then sel=9 with in_valid=0 -> out=0x1000_0005 with out_valid=1 for one cycle. out stays 0x1000_0005 afterwards with out_valid=0.
- Stall: issue sel=7, assert stall for 4 cycles after the first edge -> out=0x1000_0007 appears at cycle 3+4=7. No change while stalled, and busy=1 throughout.
- Flush priority: three requests in flight, then flush=1 together with stall=1 and a new request -> all valid bits clear next edge, out_valid=0, busy=0, out unchanged.
- Parameter corners:
  - NUM_IN=2, WIDTH=8, REG_EVERY=1: sel=1, d={0xA5,0x3C} -> out=0xA5 after 1 cycle.
  - NUM_IN=8, REG_EVERY=4 (S=1): sel=6 -> out=d[6] after 1 cycle.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// ---------------------------------------------------------------------------
// mux_tree_pipe
//   Pipelined NUM_IN-to-1 word multiplexer built as a binary tree of 2:1
//   levels. A register stage follows every REG_EVERY levels. Each stage keeps
//   its surviving partial words, the select bits later levels still need,
//   and a valid bit. The tree is LSB-first: level j uses sel[j].
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears valid, data and sel state
//   in_valid   current d/sel form a request
//   sel        index of the input to pick (log2(NUM_IN) bits)
//   d          packed inputs; input k is d[k*WIDTH +: WIDTH]
//   stall      freeze every pipeline register
//   flush      drop every in-flight request (wins over stall)
//   out        final-stage word; keeps the last result while out_valid=0
//   out_valid  out carries a result this cycle
//   busy       OR of all stage valid bits, including the final stage
// ---------------------------------------------------------------------------
module mux_tree_pipe #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 32,
  parameter int REG_EVERY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [$clog2(NUM_IN)-1:0]  sel,
  input  logic [NUM_IN*WIDTH-1:0]    d,
  input  logic                       stall,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic                       busy
);

  localparam int SELW = $clog2(NUM_IN);
  localparam int L    = SELW;
  localparam int S    = (L + REG_EVERY - 1) / REG_EVERY;

  // vchain[s] is the valid bit entering stage s; vchain[s+1] is the one it holds.
  logic [S-1:0] vld_q;
  logic [S:0]   vchain;

  assign vchain = {vld_q, in_valid};

  // NOTE: registers are written with <= so every flop samples pre-edge values
  // regardless of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q <= vchain[S-1:0];
    end
  end

  assign out_valid = vchain[S];
  assign busy      = |vchain[S:1];

  for (genvar s = 0; s < S; s++) begin : g_stage
    // Tree levels [LO, HI) are evaluated combinationally in this stage.
    localparam int LO   = s * REG_EVERY;
    localparam int HI   = ((s + 1) * REG_EVERY < L) ? (s + 1) * REG_EVERY : L;
    localparam int NLV  = HI - LO;
    localparam int NIN  = NUM_IN >> LO;
    localparam int NOUT = NUM_IN >> HI;
    localparam int SIN  = SELW - LO;
    localparam int SOUT = SELW - HI;

    logic [NIN*WIDTH-1:0]  data_in;
    logic [SIN-1:0]        sel_in;
    logic [WIDTH-1:0]      tree [NIN];
    logic [NOUT*WIDTH-1:0] data_nxt;
    logic [NOUT*WIDTH-1:0] data_q;

    if (s == 0) begin : g_src
      assign data_in = d;
      assign sel_in  = sel;
    end else begin : g_src
      assign data_in = g_stage[s-1].data_q;
      assign sel_in  = g_stage[s-1].g_selreg.sel_q;
    end

    // Levels are reduced in place: entry i only reads entries 2i and 2i+1,
    // which are never lower than i, so nothing is overwritten before use.
    // NOTE: blocking assignments here are intentional; each level must see
    // the previous level's result within the same evaluation.
    always_comb begin
      // NOTE: data_nxt gets a full default before the loop so no bit can
      // hold a previous value and infer a latch.
      data_nxt = '0;
      for (int k = 0; k < NIN; k++) begin
        tree[k] = data_in[k*WIDTH +: WIDTH];
      end
      for (int j = 0; j < NLV; j++) begin
        for (int i = 0; i < (NIN >> (j + 1)); i++) begin
          tree[i] = sel_in[j] ? tree[2*i+1] : tree[2*i];
        end
      end
      for (int k = 0; k < NOUT; k++) begin
        data_nxt[k*WIDTH +: WIDTH] = tree[k];
      end
    end

    // NOTE: data registers are reset as well as the valid bits, because out
    // must read zero after reset rather than whatever was left in flight.
    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= '0;
      end else if (!flush && !stall && vchain[s]) begin
        data_q <= data_nxt;
      end
    end

    // The last stage has consumed every select bit, so it carries none.
    if (s < S - 1) begin : g_selreg
      logic [SOUT-1:0] sel_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          sel_q <= '0;
        end else if (!flush && !stall && vchain[s]) begin
          sel_q <= sel_in[SIN-1:NLV];
        end
      end
    end
  end

  assign out = g_stage[S-1].data_q;

endmodule
